// File: rtl/nibble_serial_adder_ctrl_if.sv
// Operand/result bus of the nibble-serial adder: an operand channel in and a result channel out.
// Each channel transfers on a rising edge where its valid and ready are both 1; valid stays up
// with stable payload until that edge, and ready may be decoded from state alone.
interface nibble_serial_adder_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;
  logic             zero;
  logic             busy;
  logic             done_valid;
  logic             done_ready;

  modport master (
    output start_valid, a, b, c_in, done_ready,
    input  start_ready, sum, c_out, overflow, zero, busy, done_valid
  );

  modport slave (
    input  start_valid, a, b, c_in, done_ready,
    output start_ready, sum, c_out, overflow, zero, busy, done_valid
  );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit adder that reuses one 4-bit carry look-ahead slice over WIDTH/4 cycles, LSB nibble
// first, with a registered carry between nibbles and valid/ready on both operand and result.
module cla_4_bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_c,
  output logic [3:0] o_sum,
  output logic       o_c,
  output logic       o_p,
  output logic       o_g
);
  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [3:0] w_c;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  assign w_c[0] = i_c;
  assign w_c[1] = w_g[0] | (w_p[0] & i_c);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_c);

  assign o_p   = &w_p;
  assign o_g   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
  assign o_c   = o_g | (o_p & i_c);
  assign o_sum = w_p ^ w_c;
endmodule

module nibble_serial_adder_ctrl #(
  parameter  int WIDTH = 16,
  localparam int N     = WIDTH / 4,
  localparam int IDXW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nibble_serial_adder_ctrl_if.slave bus,
  output logic [1:0]           o_dbg_state,
  output logic [IDXW-1:0]      o_dbg_idx,
  output logic [1:0]           o_dbg_slice_pg
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_sum;
  logic             r_c_out;
  logic             r_ovf;
  logic             r_zero;

  logic [3:0]       w_slice_sum;
  logic             w_slice_cout;
  logic             w_slice_p;
  logic             w_slice_g;
  logic [WIDTH-1:0] w_sum_next;
  logic             w_last;

  cla_4_bit u_slice (
    .i_a   (r_a[4*r_idx +: 4]),
    .i_b   (r_b[4*r_idx +: 4]),
    .i_c   (r_carry),
    .o_sum (w_slice_sum),
    .o_c   (w_slice_cout),
    .o_p   (w_slice_p),
    .o_g   (w_slice_g)
  );

  assign w_last = (r_idx == IDXW'(N - 1));

  // Full sum as it will look after this edge, so flags see the final MSB nibble.
  always_comb begin
    w_sum_next = r_sum;
    w_sum_next[4*r_idx +: 4] = w_slice_sum;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.start_valid) w_state_next = RUN;
      RUN:     if (w_last)          w_state_next = DONE;
      DONE:    if (bus.done_ready)  w_state_next = IDLE;
      default:                      w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_c_out <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start_valid) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.c_in;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_sum   <= w_sum_next;
          r_carry <= w_slice_cout;
          if (w_last) begin
            r_idx   <= '0;
            r_c_out <= w_slice_cout;
            // Carry into the MSB xor carry out of it, recovered from the MSB sum bit.
            r_ovf   <= r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_sum_next[WIDTH-1] ^ w_slice_cout;
            r_zero  <= (w_sum_next == '0);
          end else begin
            r_idx   <= r_idx + IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.start_ready = (r_state == IDLE);
  assign bus.busy        = (r_state != IDLE);
  assign bus.done_valid  = (r_state == DONE);
  assign bus.sum         = r_sum;
  assign bus.c_out       = r_c_out;
  assign bus.overflow    = r_ovf;
  assign bus.zero        = r_zero;

  assign o_dbg_state    = r_state;
  assign o_dbg_idx      = r_idx;
  assign o_dbg_slice_pg = {w_slice_p, w_slice_g};
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed and randomized bench for the nibble-serial adder with a result scoreboard.
module tb_nibble_serial_adder_ctrl;
  localparam int W    = 16;
  localparam int N    = W / 4;
  localparam int IDXW = $clog2(N);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nibble_serial_adder_ctrl_if #(.WIDTH(W)) bus ();
  logic [1:0]      dbg_state;
  logic [IDXW-1:0] dbg_idx;
  logic [1:0]      dbg_pg;

  nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .o_dbg_state    (dbg_state),
    .o_dbg_idx      (dbg_idx),
    .o_dbg_slice_pg (dbg_pg)
  );

  int vectors = 0;
  int miscompares = 0;
  // {overflow, c_out, sum}
  logic [W+1:0] exp_q[$];

  initial begin
    #2ms;
    $display("FAIL watchdog expired: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin);
    logic [W:0]   full;
    logic         ovf;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    return {ovf, full};
  endfunction

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  task automatic check_reset_state();
    check("rst_sum",         bus.sum,              '0);
    check("rst_c_out",       W'(bus.c_out),        '0);
    check("rst_overflow",    W'(bus.overflow),     '0);
    check("rst_zero",        W'(bus.zero),         '0);
    check("rst_done_valid",  W'(bus.done_valid),   '0);
    check("rst_busy",        W'(bus.busy),         '0);
    check("rst_start_ready", W'(bus.start_ready),  W'(1));
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    int n = 0;
    while (!bus.start_ready && n < 50) begin
      tick();
      n++;
    end
    check("start_ready_wait", W'(bus.start_ready), W'(1));
    bus.a = a;
    bus.b = b;
    bus.c_in = cin;
    bus.start_valid = 1'b1;
    tick();
    bus.start_valid = 1'b0;
    exp_q.push_back(model(a, b, cin));
    check("accept_busy", W'(bus.busy), W'(1));
  endtask

  task automatic wait_done();
    int cyc = 0;
    logic [W+1:0] e;
    while (!bus.done_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    bus.start_valid = 1'b0;
    check("done_timeout", W'(bus.done_valid), W'(1));
    check("latency", W'(cyc), W'(N));
    check("sb_nonempty", W'(exp_q.size() != 0), W'(1));
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("sum",      bus.sum,           e[W-1:0]);
      check("c_out",    W'(bus.c_out),     W'(e[W]));
      check("overflow", W'(bus.overflow),  W'(e[W+1]));
      check("zero",     W'(bus.zero),      W'(e[W-1:0] == '0));
    end
  endtask

  task automatic release_done(input int stall);
    bus.done_ready = 1'b0;
    repeat (stall) tick();
    bus.done_ready = 1'b1;
    tick();
    bus.done_ready = 1'b0;
    check("release_done_valid", W'(bus.done_valid), '0);
  endtask

  logic [W-1:0] held_sum;
  logic [2:0]   held_flags;

  initial begin
    bus.start_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.c_in = 1'b0;
    bus.done_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    check_reset_state();

    // Carry ripples through every nibble and wraps to zero.
    start_op(16'hFFFF, 16'h0001, 1'b0);
    wait_done();
    check("t1_sum",  bus.sum,       16'h0000);
    check("t1_cout", W'(bus.c_out), W'(1));
    check("t1_zero", W'(bus.zero),  W'(1));
    check("t1_ovf",  W'(bus.overflow), '0);
    release_done(0);

    start_op(16'h7FFF, 16'h0001, 1'b0);
    wait_done();
    check("t2a_sum", bus.sum,          16'h8000);
    check("t2a_ovf", W'(bus.overflow), W'(1));
    release_done(1);

    start_op(16'h8000, 16'h8000, 1'b0);
    wait_done();
    check("t2b_sum",  bus.sum,          16'h0000);
    check("t2b_cout", W'(bus.c_out),    W'(1));
    check("t2b_ovf",  W'(bus.overflow), W'(1));
    check("t2b_zero", W'(bus.zero),     W'(1));
    release_done(0);

    start_op(16'h1234, 16'h4321, 1'b1);
    wait_done();
    check("t3_sum", bus.sum, 16'h5556);

    // Backpressure in DONE with a new operation already offered.
    held_sum   = bus.sum;
    held_flags = {bus.c_out, bus.overflow, bus.zero};
    bus.a = 16'hAAAA;
    bus.b = 16'h5555;
    bus.c_in = 1'b1;
    bus.start_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("bp_sum",         bus.sum, held_sum);
      check("bp_flags",       W'({bus.c_out, bus.overflow, bus.zero}), W'(held_flags));
      check("bp_start_ready", W'(bus.start_ready), '0);
      check("bp_done_valid",  W'(bus.done_valid),  W'(1));
    end
    bus.done_ready = 1'b1;
    tick();
    bus.done_ready = 1'b0;
    check("bp_idle_ready", W'(bus.start_ready), W'(1));
    check("bp_idle_dv",    W'(bus.done_valid),  '0);
    check("bp_idle_sum",   bus.sum, held_sum);
    tick();
    bus.start_valid = 1'b0;
    exp_q.push_back(model(16'hAAAA, 16'h5555, 1'b1));
    check("bp_accept_busy", W'(bus.busy), W'(1));
    wait_done();
    release_done(0);

    // Reset in the middle of a carry-heavy operation.
    start_op(16'hFFFF, 16'hFFFF, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    check_reset_state();
    start_op(16'h0001, 16'h0002, 1'b0);
    wait_done();
    check("t5_sum",  bus.sum,       16'h0003);
    check("t5_cout", W'(bus.c_out), '0);
    release_done(0);

    for (int i = 0; i < 1000; i++) begin
      start_op(rnd_operand(), rnd_operand(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        // Operand traffic during RUN must be ignored.
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        bus.start_valid = 1'b1;
      end
      wait_done();
      release_done(int'($urandom_range(0, 3)));
    end

    check("sb_drained", W'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
